// File: rtl/mux10_arb_pkg.sv
// Shared constants, FSM state type and index helper for the 10:1 mux arbiter.
// Purely declarative; no logic of its own.
// Used by mux10_rr_arbiter and rr_pick.
package mux10_arb_pkg;

    localparam int ARB_NUM_IN    = 10;
    localparam int ARB_SEL_W     = 4;
    localparam int ARB_BURST_LEN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index following idx in a ring of n requesters.
    function automatic logic [ARB_SEL_W-1:0] next_idx(input logic [ARB_SEL_W-1:0] idx,
                                                      input int n);
        if (int'(idx) >= n - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit at or above start, else lowest set bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the arbiter FSM.
module rr_pick
    import mux10_arb_pkg::*;
#(
    parameter int NUM_IN = ARB_NUM_IN,
    parameter int SEL_W  = ARB_SEL_W
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [NUM_IN-1:0] upper;
    logic [NUM_IN-1:0] cand;

    // Keep only requests at or above the rotating start position.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_IN; i++)
            upper[i] = req[i] && (SEL_W'(i) >= start);
    end

    // Lowest index of the upper half wins; wrap to the full vector if it is empty.
    always_comb begin
        cand  = (|upper) ? upper : req;
        found = |req;
        idx   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--)
            if (cand[i])
                idx = SEL_W'(i);
    end

endmodule

// File: rtl/mux10_rr_arbiter.sv
// Round-robin grant/select sequencer for the 10:1 fabric mux; optional burst mode via MUX10_ARB_BURST_EN.
// Latency: in_valid to out_valid 1 cycle; back-to-back grants without bubbles.
// Backpressure: select and state freeze while out_valid is high and out_ready is low.
module mux10_rr_arbiter
    import mux10_arb_pkg::*;
#(
    parameter int NUM_IN    = ARB_NUM_IN,
    parameter int SEL_W     = ARB_SEL_W,
    parameter int BURST_LEN = ARB_BURST_LEN
) (
    input  logic              CGRA_Clock,
    input  logic              CGRA_Reset,
    input  logic [NUM_IN-1:0] in_valid,
    output logic [NUM_IN-1:0] in_ready,
    output logic [SEL_W-1:0]  select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              grant_active
);

    // Reject configurations the select bus cannot encode.
    if (NUM_IN > (1 << SEL_W) || NUM_IN < 2 || BURST_LEN < 1) begin : g_bad_param
        $error("mux10_rr_arbiter: illegal NUM_IN/SEL_W/BURST_LEN combination");
    end

    arb_state_t       state_q, state_nxt;
    logic [SEL_W-1:0] sel_q, sel_nxt;
    logic [SEL_W-1:0] last_q, last_nxt;
    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             xfer;

`ifdef MUX10_ARB_BURST_EN
    localparam int CNT_W = (BURST_LEN > 4) ? $clog2(BURST_LEN) : 2;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
`endif

    // Search starts after the last winner when idle, after the current grant when busy.
    assign pick_start = (state_q == IDLE) ? SEL_W'(next_idx(last_q, NUM_IN))
                                          : SEL_W'(next_idx(sel_q, NUM_IN));
    assign xfer       = (state_q == BUSY) && in_valid[sel_q] && out_ready;
    assign select     = sel_q;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // State register: grant index, last winner, FSM state (and burst count).
    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_IN - 1);
`ifdef MUX10_ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            last_q  <= last_nxt;
`ifdef MUX10_ARB_BURST_EN
            cnt_q   <= cnt_nxt;
`endif
        end
    end

    // Next-state: grant from idle, re-arbitrate only on a completed transfer.
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
`ifdef MUX10_ARB_BURST_EN
        cnt_nxt   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BUSY;
                    sel_nxt   = pick_idx;
`ifdef MUX10_ARB_BURST_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            BUSY: begin
                if (xfer) begin
                    last_nxt = sel_q;
`ifdef MUX10_ARB_BURST_EN
                    if (cnt_q < CNT_W'(BURST_LEN - 1)) begin
                        cnt_nxt = cnt_q + 1'b1;
                    end else if (pick_found) begin
                        sel_nxt = pick_idx;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
`else
                    // Others are searched first; the current grant is found last on wrap.
                    if (pick_found)
                        sel_nxt = pick_idx;
                    else
                        state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: steer the granted requester's handshake; everything quiet during reset.
    always_comb begin
        out_valid    = 1'b0;
        in_ready     = '0;
        grant_active = 1'b0;
        if (!CGRA_Reset && state_q == BUSY) begin
            grant_active    = 1'b1;
            out_valid       = in_valid[sel_q];
            in_ready[sel_q] = out_ready;
        end
    end

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Self-checking bench for mux10_rr_arbiter against a ring-search reference model.
// Directed scenarios plus a randomized valid-hold traffic run.
// Outputs compared on the falling edge; inputs driven just after the rising edge.
module tb_mux10_rr_arbiter;

    localparam int N  = 10;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] iv  = '0;
    logic [N-1:0] ir;
    logic [3:0]   sel;
    logic         ov;
    logic         ordy = 1'b0;
    logic         ga;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_last = N - 1;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    mux10_rr_arbiter dut (
        .CGRA_Clock   (clk),
        .CGRA_Reset   (rst),
        .in_valid     (iv),
        .in_ready     (ir),
        .select       (sel),
        .out_valid    (ov),
        .out_ready    (ordy),
        .grant_active (ga)
    );

    // First requesting index found walking the ring from start; -1 if none.
    function automatic int first_from(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N])
                return (start + k) % N;
        return -1;
    endfunction

    // Expected {select, out_valid, in_ready, grant_active} for the current cycle.
    function automatic logic [15:0] exp_vec();
        logic [N-1:0] r = '0;
        logic         v = 1'b0;
        logic         g = 1'b0;
        if (!rst && m_busy) begin
            g        = 1'b1;
            v        = iv[m_sel];
            r[m_sel] = ordy;
        end
        return {4'(m_sel), v, r, g};
    endfunction

    task automatic model_edge();
        int nx;
        if (rst) begin
            m_busy = 1'b0; m_sel = 0; m_last = N - 1; m_cnt = 0;
        end else if (!m_busy) begin
            nx = first_from(iv, (m_last + 1) % N);
            if (nx >= 0) begin
                m_busy = 1'b1; m_sel = nx; m_cnt = 0;
            end
        end else if (iv[m_sel] && ordy) begin
            m_last = m_sel;
`ifdef MUX10_ARB_BURST_EN
            if (m_cnt + 1 < BL) begin
                m_cnt = m_cnt + 1;
            end else begin
                nx = first_from(iv, (m_sel + 1) % N);
                if (nx < 0) m_busy = 1'b0; else m_sel = nx;
                m_cnt = 0;
            end
`else
            nx = first_from(iv, (m_sel + 1) % N);
            if (nx < 0) m_busy = 1'b0; else m_sel = nx;
`endif
        end
    endtask

    task automatic edge_advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; iv = '0; ordy = 1'b0;
        repeat (2) edge_advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1; iv = '0; ordy = 1'b0;
        edge_advance();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst = 1'b0;
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL reset_model[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            total++;
            if ({sel, ov, ir, ga} !== 16'h0000) begin
                bad++; $display("FAIL reset_idle[%0d] got=%h want=0000", c, {sel, ov, ir, ga});
            end
            edge_advance();
        end
    endtask

    task automatic test_single();
        logic [15:0] e;
        do_reset();
        iv = 10'h008; ordy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL single[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            if (c >= 1) begin
                total++;
                if (sel !== 4'd3 || ov !== 1'b1 || ir !== 10'h008) begin
                    bad++; $display("FAIL single_sel3[%0d] got sel=%0d ov=%b ir=%h want sel=3 ov=1 ir=008", c, sel, ov, ir);
                end
            end
            edge_advance();
        end
    endtask

    task automatic test_contention();
        logic [15:0] e;
        do_reset();
        iv = 10'h3FF; ordy = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL contention[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
`ifndef MUX10_ARB_BURST_EN
            if (c >= 1) begin
                total++;
                if (sel !== 4'((c - 1) % N) || ov !== 1'b1) begin
                    bad++; $display("FAIL contention_seq[%0d] got sel=%0d ov=%b want sel=%0d ov=1", c, sel, ov, (c - 1) % N);
                end
            end
`endif
            edge_advance();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            iv   = (c >= 5) ? 10'h004 : 10'h005;
            ordy = (c >= 4);
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL backpressure[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
`ifndef MUX10_ARB_BURST_EN
            if (c >= 1) begin
                total++;
                if (sel !== ((c >= 5) ? 4'd2 : 4'd0)) begin
                    bad++; $display("FAIL backpressure_sel[%0d] got=%0d want=%0d", c, sel, (c >= 5) ? 2 : 0);
                end
            end
`endif
            edge_advance();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        bit reached = 1'b0;
        do_reset();
        iv = 10'h3FF; ordy = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (m_busy && m_sel == 7) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL reset_mid_run[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            edge_advance();
        end
        total++;
        if (!reached) begin
            bad++; $display("FAIL reset_mid_reach got=timeout want=select 7");
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ir !== 10'h000 || ov !== 1'b0) begin
            bad++; $display("FAIL reset_mid_gate got ir=%h ov=%b want ir=000 ov=0", ir, ov);
        end
        edge_advance();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sel !== 4'd0 || ga !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle got sel=%0d ga=%b want sel=0 ga=0", sel, ga);
        end
        edge_advance();
        @(negedge clk);
        e = exp_vec();
        total++;
        if ({sel, ov, ir, ga} !== e || sel !== 4'd0 || ov !== 1'b1) begin
            bad++; $display("FAIL reset_mid_first got=%h want=%h (sel 0, ov 1)", {sel, ov, ir, ga}, e);
        end
        edge_advance();
    endtask

    task automatic test_withdraw();
        logic [15:0] e;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            iv   = (c == 0) ? 10'h008 : (c <= 3) ? 10'h030 : 10'h038;
            ordy = (c >= 1);
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL withdraw[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            if (c >= 1 && c <= 3) begin
                total++;
                if (sel !== 4'd3 || ov !== 1'b0 || ga !== 1'b1) begin
                    bad++; $display("FAIL withdraw_hold[%0d] got sel=%0d ov=%b ga=%b want sel=3 ov=0 ga=1", c, sel, ov, ga);
                end
            end
            edge_advance();
        end
    endtask

`ifdef MUX10_ARB_BURST_EN
    task automatic test_burst();
        logic [15:0] e;
        do_reset();
        iv = 10'h003; ordy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL burst[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            if (c >= 1) begin
                total++;
                if (sel !== 4'(((c - 1) / BL) % 2)) begin
                    bad++; $display("FAIL burst_seq[%0d] got=%0d want=%0d", c, sel, ((c - 1) / BL) % 2);
                end
            end
            edge_advance();
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0]  e;
        logic [N-1:0] nxt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            e = exp_vec();
            total++;
            if ({sel, ov, ir, ga} !== e) begin
                bad++; $display("FAIL random[%0d] got=%h want=%h", c, {sel, ov, ir, ga}, e);
            end
            edge_advance();
            // Requesters hold valid until their ready was seen, then may re-request.
            nxt = iv & ~e[10:1];
            for (int i = 0; i < N; i++)
                if (!nxt[i] && $urandom_range(0, 3) == 0)
                    nxt[i] = 1'b1;
            iv = nxt;
        end
        rst = 1'b0;
        iv  = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_withdraw();
`ifdef MUX10_ARB_BURST_EN
        test_burst();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
